gfm_n_div: RTL and testbench



---
 rtl/gfm_n_div_if.sv | 23 ++
 rtl/gfm_n_div.sv | 159 +++++++++++++++
 tb/tb_gfm_n_div.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gfm_n_div_if.sv
// Request/status bundle of the glitch-free N-way clock divider.
// The master side issues channel requests; the slave side is the divider itself.
interface gfm_n_div_if #(
   parameter int SEL_W = 2
);
   logic [SEL_W-1:0] sel;
   logic             sel_req;
   logic             sel_ack;
   logic             sel_err;
   logic             busy;
   logic [SEL_W-1:0] cur_sel;
   logic             clk_out;

   modport master (
      output sel, sel_req,
      input  sel_ack, sel_err, busy, cur_sel, clk_out
   );

   modport slave (
      input  sel, sel_req,
      output sel_ack, sel_err, busy, cur_sel, clk_out
   );
endinterface

// File: rtl/gfm_n_div.sv
// Glitch-free N-way divided-clock selector: channel k toggles every k+1 source cycles.
// Optional output gating is enabled with the GFM_GATE_EN macro (adds i_gate_en).
module gfm_n_div #(
   parameter int NUM_CH    = 4,
   parameter int SEL_W     = $clog2(NUM_CH),
   parameter int GAP_CYC   = 2,
   parameter int RESET_SEL = 0
) (
   input  logic           i_clk,
   input  logic           i_rstn,
`ifdef GFM_GATE_EN
   input  logic           i_gate_en,
`endif
   gfm_n_div_if.slave     io_if
);

   localparam int PARK_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
   localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_PARK  = 2'd2,
      ST_GATED = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_clk_out;
   logic [SEL_W-1:0]  r_half_cnt;
   logic [SEL_W-1:0]  r_cur_sel;
   logic [SEL_W-1:0]  r_pend_sel;
   logic [PARK_W-1:0] r_park_cnt;
   logic              r_busy;
   logic              r_sel_ack;
   logic              r_sel_err;
   logic              r_ack_pend;

   logic              w_gate_en;
   logic              w_half_last;
   logic              w_clk_nxt;
   logic              w_sel_ok;
   logic              w_park_last;

`ifdef GFM_GATE_EN
   assign w_gate_en = i_gate_en;
`else
   assign w_gate_en = 1'b1;
`endif

   // H(k)-1 equals k, so the half-period terminal count is the channel index itself.
   assign w_half_last = (r_half_cnt == r_cur_sel);
   assign w_clk_nxt   = w_half_last ? ~r_clk_out : r_clk_out;
   assign w_sel_ok    = (32'(io_if.sel) < 32'(NUM_CH));
   assign w_park_last = ((32'(r_park_cnt) + 32'd1) >= 32'(GAP_CYC));

   // Divider, switch sequencer and registered status outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state    <= ST_RUN;
         r_clk_out  <= 1'b0;
         r_half_cnt <= '0;
         r_cur_sel  <= RST_SEL;
         r_pend_sel <= RST_SEL;
         r_park_cnt <= '0;
         r_busy     <= 1'b0;
         r_sel_ack  <= 1'b0;
         r_sel_err  <= 1'b0;
         r_ack_pend <= 1'b0;
      end else begin
         r_sel_ack <= 1'b0;
         r_sel_err <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (w_half_last) begin
                  r_clk_out  <= ~r_clk_out;
                  r_half_cnt <= '0;
               end else begin
                  r_half_cnt <= r_half_cnt + SEL_W'(1'b1);
               end
               // A request that would land in a low phase skips DRAIN: that phase only gets longer.
               if (!w_gate_en) begin
                  r_pend_sel <= r_cur_sel;
                  r_ack_pend <= 1'b0;
                  r_busy     <= 1'b1;
                  r_park_cnt <= '0;
                  r_state    <= w_clk_nxt ? ST_DRAIN : ST_GATED;
               end else if (io_if.sel_req) begin
                  if (!w_sel_ok) begin
                     r_sel_err <= 1'b1;
                  end else if (io_if.sel == r_cur_sel) begin
                     r_sel_ack <= 1'b1;
                  end else begin
                     r_pend_sel <= io_if.sel;
                     r_ack_pend <= 1'b1;
                     r_busy     <= 1'b1;
                     r_park_cnt <= '0;
                     r_state    <= w_clk_nxt ? ST_DRAIN : ST_PARK;
                  end
               end else begin
                  r_state <= ST_RUN;
               end
            end

            ST_DRAIN: begin
               if (!r_clk_out) begin
                  r_park_cnt <= '0;
                  r_state    <= w_gate_en ? ST_PARK : ST_GATED;
               end else if (w_half_last) begin
                  r_clk_out  <= 1'b0;
                  r_half_cnt <= '0;
                  r_park_cnt <= '0;
                  r_state    <= w_gate_en ? ST_PARK : ST_GATED;
               end else begin
                  r_half_cnt <= r_half_cnt + SEL_W'(1'b1);
               end
            end

            ST_PARK: begin
               if (!w_gate_en) begin
                  r_park_cnt <= '0;
                  r_state    <= ST_GATED;
               end else if (w_park_last) begin
                  r_cur_sel  <= r_pend_sel;
                  r_half_cnt <= '0;
                  r_sel_ack  <= r_ack_pend;
                  r_ack_pend <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= ST_RUN;
               end else begin
                  r_park_cnt <= r_park_cnt + PARK_W'(1'b1);
               end
            end

            ST_GATED: begin
               if (w_gate_en) begin
                  r_park_cnt <= '0;
                  r_state    <= ST_PARK;
               end else begin
                  r_state    <= ST_GATED;
               end
            end

            default: begin
               r_state    <= ST_RUN;
               r_clk_out  <= 1'b0;
               r_half_cnt <= '0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign io_if.clk_out = r_clk_out;
   assign io_if.cur_sel = r_cur_sel;
   assign io_if.busy    = r_busy;
   assign io_if.sel_ack = r_sel_ack;
   assign io_if.sel_err = r_sel_err;

endmodule

// File: tb/tb_gfm_n_div.sv
// Directed bench for gfm_n_div: reset, 0->3 and 3->2 switches, same-channel ack,
// illegal select, busy-time requests, reset mid-switch and (with GFM_GATE_EN) gating.
module tb_gfm_n_div;
   localparam int NUM_CH    = 4;
   localparam int SEL_W     = 3;
   localparam int GAP_CYC   = 2;
   localparam int RESET_SEL = 0;

   logic clk     = 1'b0;
   logic rstn    = 1'b0;
   logic gate_en = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   gfm_n_div_if #(.SEL_W(SEL_W)) bus ();

   gfm_n_div #(
      .NUM_CH    (NUM_CH),
      .SEL_W     (SEL_W),
      .GAP_CYC   (GAP_CYC),
      .RESET_SEL (RESET_SEL)
   ) dut (
      .i_clk     (clk),
      .i_rstn    (rstn),
`ifdef GFM_GATE_EN
      .i_gate_en (gate_en),
`endif
      .io_if     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.sel     = 3'd0;
      bus.sel_req = 1'b0;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_clk", 32'(bus.clk_out), 32'd0);
         chk("rst_cur", 32'(bus.cur_sel), 32'd0);
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_ack", 32'(bus.sel_ack), 32'd0);
      end
      rstn = 1'b1;

      // Channel 0: toggle every cycle, first rise one cycle after release.
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk("ch0_clk", 32'(bus.clk_out), 32'(e % 2));
      end

      // 0 -> 3 with clk_out high: fall, two PARK cycles, ack, four low cycles, period 8.
      bus.sel = 3'd3; bus.sel_req = 1'b1;
      tick();
      chk("sw03_clk_a", 32'(bus.clk_out), 32'd0);
      chk("sw03_busy_a", 32'(bus.busy), 32'd1);
      chk("sw03_ack_a", 32'(bus.sel_ack), 32'd0);
      bus.sel_req = 1'b0;
      tick();
      chk("sw03_clk_b", 32'(bus.clk_out), 32'd0);
      chk("sw03_busy_b", 32'(bus.busy), 32'd1);
      chk("sw03_ack_b", 32'(bus.sel_ack), 32'd0);
      tick();
      chk("sw03_ack", 32'(bus.sel_ack), 32'd1);
      chk("sw03_busy_c", 32'(bus.busy), 32'd0);
      chk("sw03_cur", 32'(bus.cur_sel), 32'd3);
      chk("sw03_clk_c", 32'(bus.clk_out), 32'd0);
      for (int n = 1; n <= 21; n++) begin
         tick();
         chk("ch3_clk", 32'(bus.clk_out), 32'((n / 4) % 2));
         if (n == 1) chk("ch3_ack_drop", 32'(bus.sel_ack), 32'd0);
      end

      // 3 -> 2 during a high phase: the 4-cycle high completes before PARK.
      bus.sel = 3'd2; bus.sel_req = 1'b1;
      tick();
      chk("sw32_clk_a", 32'(bus.clk_out), 32'd1);
      chk("sw32_busy_a", 32'(bus.busy), 32'd1);
      chk("sw32_ack_a", 32'(bus.sel_ack), 32'd0);
      bus.sel_req = 1'b0;
      tick();
      chk("sw32_clk_b", 32'(bus.clk_out), 32'd1);
      tick();
      chk("sw32_clk_c", 32'(bus.clk_out), 32'd0);
      chk("sw32_busy_c", 32'(bus.busy), 32'd1);
      tick();
      chk("sw32_clk_d", 32'(bus.clk_out), 32'd0);
      chk("sw32_ack_d", 32'(bus.sel_ack), 32'd0);
      tick();
      chk("sw32_ack", 32'(bus.sel_ack), 32'd1);
      chk("sw32_busy_e", 32'(bus.busy), 32'd0);
      chk("sw32_cur", 32'(bus.cur_sel), 32'd2);
      chk("sw32_clk_e", 32'(bus.clk_out), 32'd0);
      for (int m = 1; m <= 4; m++) begin
         tick();
         chk("ch2_clk", 32'(bus.clk_out), 32'((m / 3) % 2));
      end

      // Same-channel request: ack next cycle, divider undisturbed.
      bus.sel = 3'd2; bus.sel_req = 1'b1;
      tick();
      chk("same_ack", 32'(bus.sel_ack), 32'd1);
      chk("same_busy", 32'(bus.busy), 32'd0);
      chk("same_clk", 32'(bus.clk_out), 32'd1);
      chk("same_cur", 32'(bus.cur_sel), 32'd2);
      bus.sel_req = 1'b0;
      for (int m = 6; m <= 10; m++) begin
         tick();
         chk("same_ref_clk", 32'(bus.clk_out), 32'((m / 3) % 2));
         if (m == 6) chk("same_ack_drop", 32'(bus.sel_ack), 32'd0);
      end

      // Illegal select: one err pulse, nothing else moves.
      bus.sel = 3'd5; bus.sel_req = 1'b1;
      tick();
      chk("err_pulse", 32'(bus.sel_err), 32'd1);
      chk("err_ack", 32'(bus.sel_ack), 32'd0);
      chk("err_busy", 32'(bus.busy), 32'd0);
      chk("err_cur", 32'(bus.cur_sel), 32'd2);
      chk("err_clk", 32'(bus.clk_out), 32'd1);
      bus.sel_req = 1'b0;
      tick();
      chk("err_drop", 32'(bus.sel_err), 32'd0);
      chk("err_clk_b", 32'(bus.clk_out), 32'd0);

      // 2 -> 1 from a low phase; a second request held while busy is ignored.
      bus.sel = 3'd1; bus.sel_req = 1'b1;
      tick();
      chk("sw21_busy_a", 32'(bus.busy), 32'd1);
      chk("sw21_clk_a", 32'(bus.clk_out), 32'd0);
      chk("sw21_ack_a", 32'(bus.sel_ack), 32'd0);
      bus.sel = 3'd3;
      tick();
      chk("busyreq_ack", 32'(bus.sel_ack), 32'd0);
      chk("busyreq_err", 32'(bus.sel_err), 32'd0);
      chk("busyreq_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("sw21_ack", 32'(bus.sel_ack), 32'd1);
      chk("sw21_err", 32'(bus.sel_err), 32'd0);
      chk("sw21_cur", 32'(bus.cur_sel), 32'd1);
      chk("sw21_busy_c", 32'(bus.busy), 32'd0);
      bus.sel_req = 1'b0;
      tick();
      chk("sw21_ack_drop", 32'(bus.sel_ack), 32'd0);
      chk("sw21_clk_d", 32'(bus.clk_out), 32'd0);

      // Reset during PARK of a 0 -> 3 switch aborts it without an ack.
      rstn = 1'b0;
      tick();
      chk("rst2_cur", 32'(bus.cur_sel), 32'd0);
      rstn = 1'b1;
      tick();
      chk("rst2_clk_a", 32'(bus.clk_out), 32'd1);
      bus.sel = 3'd3; bus.sel_req = 1'b1;
      tick();
      chk("abort_busy", 32'(bus.busy), 32'd1);
      chk("abort_clk", 32'(bus.clk_out), 32'd0);
      bus.sel_req = 1'b0;
      rstn = 1'b0;
      tick();
      chk("abort_cur", 32'(bus.cur_sel), 32'd0);
      chk("abort_busy_clr", 32'(bus.busy), 32'd0);
      chk("abort_clk_low", 32'(bus.clk_out), 32'd0);
      chk("abort_ack", 32'(bus.sel_ack), 32'd0);
      rstn = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         chk("abort_no_ack", 32'(bus.sel_ack), 32'd0);
         chk("abort_ch0_clk", 32'(bus.clk_out), 32'(e % 2));
      end

`ifdef GFM_GATE_EN
      // Move to channel 1, then gate during its high phase and ungate after 10 low cycles.
      bus.sel = 3'd1; bus.sel_req = 1'b1;
      tick();
      chk("g_sw_busy", 32'(bus.busy), 32'd1);
      bus.sel_req = 1'b0;
      tick();
      tick();
      chk("g_sw_ack", 32'(bus.sel_ack), 32'd1);
      chk("g_sw_cur", 32'(bus.cur_sel), 32'd1);
      for (int k = 1; k <= 2; k++) begin
         tick();
         chk("g_ch1_clk", 32'(bus.clk_out), 32'((k / 2) % 2));
      end
      gate_en = 1'b0;
      tick();
      chk("g_high_hold", 32'(bus.clk_out), 32'd1);
      chk("g_busy", 32'(bus.busy), 32'd1);
      for (int k = 4; k <= 13; k++) begin
         tick();
         chk("g_low_clk", 32'(bus.clk_out), 32'd0);
         chk("g_low_busy", 32'(bus.busy), 32'd1);
      end
      gate_en = 1'b1;
      for (int k = 14; k <= 17; k++) begin
         tick();
         chk("ug_low_clk", 32'(bus.clk_out), 32'd0);
         chk("ug_no_ack", 32'(bus.sel_ack), 32'd0);
         if (k == 16) chk("ug_busy_clr", 32'(bus.busy), 32'd0);
      end
      tick();
      chk("ug_rise", 32'(bus.clk_out), 32'd1);
      chk("ug_cur", 32'(bus.cur_sel), 32'd1);
      chk("ug_ack", 32'(bus.sel_ack), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
